// File: rtl/tlb_pcid.sv
// PCID-tagged set-associative first-level TLB: combinational lookup, insert on
// strobe, invalid-first then tree pseudo-LRU replacement per set.
module tlb_pcid #(
   parameter int SADDR = 64,
   parameter int SPAGE = 12,
   parameter int NSET  = 8,
   parameter int NWAY  = 8,
   parameter int SPCID = 12
) (
   input  logic             clk,
   input  logic             shutdown_n,
   input  logic             insert,
   input  logic [SADDR-1:0] va,
   input  logic [SADDR-1:0] pa,
   input  logic [SPCID-1:0] pcid,
   output logic [SADDR-1:0] o_addr,
   output logic             hit,
   output logic             miss
);

   localparam int SIDX = $clog2(NSET);
   localparam int SWAY = $clog2(NWAY);
   localparam int SVPN = SADDR - SPAGE;
   localparam int STAG = SVPN - SIDX;
   localparam int SENT = STAG + SPCID + SVPN;

   // Entry = {tag, pcid, ppn}; PPN in the low bits.
   logic [SENT-1:0] entry_q [NSET][NWAY];
   logic [NWAY-1:0] valid_q [NSET];
   logic [NWAY-2:0] plru_q  [NSET];

   logic [SVPN-1:0] vpn;
   logic [SIDX-1:0] set_idx;
   logic [STAG-1:0] tag;

   assign vpn     = va[SADDR-1:SPAGE];
   assign set_idx = vpn[SIDX-1:0];
   assign tag     = vpn[SVPN-1:SIDX];

   logic            hit_w;
   logic [SWAY-1:0] hit_way;
   logic [SVPN-1:0] hit_ppn;

   always_comb begin : lookup
      hit_w   = 1'b0;
      hit_way = '0;
      hit_ppn = '0;
      for (int w = 0; w < NWAY; w++) begin
         if (valid_q[set_idx][w] && (entry_q[set_idx][w][SENT-1:SVPN] == {tag, pcid})) begin
            hit_w   = 1'b1;
            hit_way = SWAY'(w);
            hit_ppn = entry_q[set_idx][w][SVPN-1:0];
         end
      end
   end

   assign hit    = hit_w;
   assign miss   = ~hit_w;
   assign o_addr = hit_w ? {hit_ppn, va[SPAGE-1:0]} : '0;

   logic            inv_found;
   logic [SWAY-1:0] inv_way;
   logic [SWAY-1:0] plru_way;
   logic [SWAY-1:0] vic_way;
   logic [NWAY-2:0] plru_cur;
   int              node_v;

   // Tree nodes use heap numbering: node n has children 2n+1 and 2n+2.
   always_comb begin : victim
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NWAY - 1; w >= 0; w--) begin
         if (!valid_q[set_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = SWAY'(w);
         end
      end
      plru_cur = plru_q[set_idx];
      plru_way = '0;
      node_v   = 0;
      for (int l = 0; l < SWAY; l++) begin
         node_v = (1 << l) - 1 + int'(plru_way >> (SWAY - l));
         plru_way[SWAY-1-l] = plru_cur[SWAY'(node_v)];
      end
      vic_way = inv_found ? inv_way : plru_way;
   end

   logic [SWAY-1:0] acc_way;
   logic [NWAY-2:0] plru_d;
   int              node_u;

   // Every node on the accessed way's path is turned to point away from it.
   always_comb begin : plru_update
      acc_way = hit_w ? hit_way : vic_way;
      plru_d  = plru_cur;
      node_u  = 0;
      for (int l = 0; l < SWAY; l++) begin
         node_u = (1 << l) - 1 + int'(acc_way >> (SWAY - l));
         plru_d[SWAY'(node_u)] = ~acc_way[SWAY-1-l];
      end
   end

   always_ff @(posedge clk) begin
      if (!shutdown_n) begin
         for (int s = 0; s < NSET; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (hit_w || insert) plru_q[set_idx] <= plru_d;
         if (insert && !hit_w) valid_q[set_idx][vic_way] <= 1'b1;
      end
   end

   // Payloads carry no reset; validity alone decides what is visible.
   always_ff @(posedge clk) begin
      if (shutdown_n && insert) begin
         if (hit_w) entry_q[set_idx][hit_way][SVPN-1:0] <= pa[SADDR-1:SPAGE];
         else       entry_q[set_idx][vic_way]           <= {tag, pcid, pa[SADDR-1:SPAGE]};
      end
   end

endmodule

// File: tb/tb_tlb_pcid.sv
// Bench for tlb_pcid: directed scenarios plus randomized traffic against an
// entry-list reference model with range-halving pseudo-LRU.
module tb_tlb_pcid;

   logic        clk;
   logic        shutdown_n;
   logic        insert;
   logic [63:0] va;
   logic [63:0] pa;
   logic [11:0] pcid;
   logic [63:0] o_addr;
   logic        hit;
   logic        miss;

   int total = 0;
   int bad   = 0;

   tlb_pcid dut (
      .clk(clk), .shutdown_n(shutdown_n), .insert(insert), .va(va), .pa(pa),
      .pcid(pcid), .o_addr(o_addr), .hit(hit), .miss(miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_valid [8][8];
   logic [51:0] m_vpn   [8][8];
   logic [11:0] m_pcid  [8][8];
   logic [51:0] m_ppn   [8][8];
   bit          m_plru  [8][7];

   function automatic void m_find(input logic [63:0] a, input logic [11:0] p,
                                  output bit h, output int way);
      int s;
      s = int'(a[14:12]);
      h = 1'b0;
      way = 0;
      for (int w = 0; w < 8; w++)
         if (m_valid[s][w] && m_vpn[s][w] == a[63:12] && m_pcid[s][w] == p) begin
            h = 1'b1;
            way = w;
         end
   endfunction

   function automatic int m_victim(input int s);
      int lo, size, node, half;
      for (int w = 0; w < 8; w++) if (!m_valid[s][w]) return w;
      lo = 0; size = 8; node = 0;
      while (size > 1) begin
         half = size / 2;
         if (m_plru[s][node]) begin lo += half; node = 2 * node + 2; end
         else node = 2 * node + 1;
         size = half;
      end
      return lo;
   endfunction

   function automatic void m_touch(input int s, input int way);
      int lo, size, node, half;
      lo = 0; size = 8; node = 0;
      while (size > 1) begin
         half = size / 2;
         if (way < lo + half) begin m_plru[s][node] = 1'b1; node = 2 * node + 1; end
         else begin m_plru[s][node] = 1'b0; lo += half; node = 2 * node + 2; end
         size = half;
      end
   endfunction

   function automatic logic [6:0] m_plru_vec(input int s);
      logic [6:0] v;
      for (int n = 0; n < 7; n++) v[n] = m_plru[s][n];
      return v;
   endfunction

   function automatic logic [63:0] m_addr(input logic [63:0] a, input logic [11:0] p);
      bit h;
      int w;
      m_find(a, p, h, w);
      return h ? {m_ppn[int'(a[14:12])][w], a[11:0]} : 64'h0;
   endfunction

   function automatic bit m_hit(input logic [63:0] a, input logic [11:0] p);
      bit h;
      int w;
      m_find(a, p, h, w);
      return h;
   endfunction

   always @(posedge clk) begin : model_step
      bit h;
      int w, s;
      if (!shutdown_n) begin
         for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) m_valid[i][j] = 1'b0;
         for (int i = 0; i < 8; i++)
            for (int n = 0; n < 7; n++) m_plru[i][n] = 1'b0;
      end else begin
         s = int'(va[14:12]);
         m_find(va, pcid, h, w);
         if (insert) begin
            if (h) m_ppn[s][w] = pa[63:12];
            else begin
               w = m_victim(s);
               m_valid[s][w] = 1'b1;
               m_vpn[s][w]   = va[63:12];
               m_pcid[s][w]  = pcid;
               m_ppn[s][w]   = pa[63:12];
            end
         end
         if (h || insert) m_touch(s, w);
      end
   end

   // ---------------- driver ----------------
   localparam logic [63:0] VA7 = 64'hFFFF_FFFF_FFFF_FFF1;

   task automatic drive(input bit rst_n, input bit ins, input logic [63:0] a,
                        input logic [63:0] b, input logic [11:0] p);
      @(negedge clk);
      shutdown_n = rst_n;
      insert     = ins;
      va         = a;
      pa         = b;
      pcid       = p;
      #1;
   endtask

   function automatic logic [63:0] pa_of(input int p);
      return 64'h0000_00AB_0000_0000 + (64'(p) << 12);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(1'b0, 1'b1, VA7, 64'h0, 12'd0);
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd0);
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", hit); end
      total++; if (miss !== 1'b1) begin bad++; $display("FAIL reset_miss got=%b want=1", miss); end
      total++; if (o_addr !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", o_addr); end
      total++; if (dut.plru_q[7] !== 7'b0) begin bad++; $display("FAIL reset_plru got=%b want=0", dut.plru_q[7]); end
   endtask

   task automatic test_insert();
      drive(1'b1, 1'b1, VA7, 64'h0000_0012_3456_7000, 12'd0);
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd0);
      total++; if (hit !== 1'b1) begin bad++; $display("FAIL ins_hit got=%b want=1", hit); end
      total++; if (o_addr !== 64'h0000_0012_3456_7FF1) begin bad++; $display("FAIL ins_addr got=%h want=0000001234567ff1", o_addr); end
      total++; if (dut.valid_q[7] !== 8'h01) begin bad++; $display("FAIL ins_way got=%b want=00000001", dut.valid_q[7]); end
      total++; if (dut.plru_q[7] !== 7'b0001011) begin bad++; $display("FAIL ins_plru got=%b want=0001011", dut.plru_q[7]); end
   endtask

   task automatic test_pcid_toggle();
      logic [11:0] p;
      for (int c = 0; c < 40; c++) begin
         p = 12'((c / 10) % 2);
         drive(1'b1, 1'b0, VA7, 64'h0, p);
         total++; if (hit !== (p == 12'd0)) begin bad++; $display("FAIL toggle_hit c=%0d got=%b want=%b", c, hit, p == 12'd0); end
         total++; if (o_addr !== (p == 12'd0 ? 64'h0000_0012_3456_7FF1 : 64'h0)) begin bad++; $display("FAIL toggle_addr c=%0d got=%h", c, o_addr); end
      end
   endtask

   task automatic test_fill_replace();
      for (int p = 1; p < 8; p++) drive(1'b1, 1'b1, VA7, pa_of(p), 12'(p));
      drive(1'b1, 1'b0, 64'h0, 64'h0, 12'd0);
      total++; if (dut.valid_q[7] !== 8'hFF) begin bad++; $display("FAIL fill_valid got=%b want=11111111", dut.valid_q[7]); end
      total++; if (dut.plru_q[7] !== m_plru_vec(7)) begin bad++; $display("FAIL fill_plru got=%b want=%b", dut.plru_q[7], m_plru_vec(7)); end
      drive(1'b1, 1'b1, VA7, pa_of(8), 12'd8);
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd0);
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL evict_pcid0 got=%b want=0", hit); end
      for (int p = 1; p <= 8; p++) begin
         drive(1'b1, 1'b0, VA7, 64'h0, 12'(p));
         total++; if (hit !== 1'b1) begin bad++; $display("FAIL fill_hit p=%0d got=%b want=1", p, hit); end
         total++; if (o_addr !== (pa_of(p) | 64'hFF1)) begin bad++; $display("FAIL fill_addr p=%0d got=%h want=%h", p, o_addr, pa_of(p) | 64'hFF1); end
      end
   endtask

   task automatic test_reinsert();
      drive(1'b1, 1'b1, VA7, 64'h0000_0777_7777_7000, 12'd3);
      drive(1'b1, 1'b1, VA7, 64'h0000_0777_7777_7000, 12'd3);
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd3);
      total++; if (o_addr !== 64'h0000_0777_7777_7FF1) begin bad++; $display("FAIL reins_addr got=%h want=0000077777777ff1", o_addr); end
      total++; if (dut.plru_q[7] !== m_plru_vec(7)) begin bad++; $display("FAIL reins_plru got=%b want=%b", dut.plru_q[7], m_plru_vec(7)); end
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd4);
      total++; if (o_addr !== (pa_of(4) | 64'hFF1)) begin bad++; $display("FAIL reins_other got=%h want=%h", o_addr, pa_of(4) | 64'hFF1); end
   endtask

   task automatic test_shutdown_pulse();
      drive(1'b0, 1'b0, VA7, 64'h0, 12'd1);
      for (int p = 1; p <= 8; p++) begin
         drive(1'b1, 1'b0, VA7, 64'h0, 12'(p));
         total++; if (miss !== 1'b1 || o_addr !== 64'h0) begin bad++; $display("FAIL pulse_miss p=%0d got miss=%b addr=%h want 1/0", p, miss, o_addr); end
      end
      total++; if (dut.plru_q[7] !== 7'b0) begin bad++; $display("FAIL pulse_plru got=%b want=0", dut.plru_q[7]); end
      drive(1'b1, 1'b1, VA7, 64'h0000_0005_5555_5000, 12'd5);
      drive(1'b1, 1'b0, VA7, 64'h0, 12'd5);
      total++; if (dut.valid_q[7] !== 8'h01) begin bad++; $display("FAIL pulse_way got=%b want=00000001", dut.valid_q[7]); end
      total++; if (o_addr !== 64'h0000_0005_5555_5FF1) begin bad++; $display("FAIL pulse_addr got=%h want=0000000555555ff1", o_addr); end
   endtask

   task automatic test_random();
      logic [48:0] tags [6];
      logic [63:0] a, b;
      logic [11:0] p;
      bit          rn, ins;
      for (int i = 0; i < 6; i++) tags[i] = {17'($urandom), $urandom};
      for (int c = 0; c < 2000; c++) begin
         rn  = ($urandom_range(0, 199) != 0);
         ins = ($urandom_range(0, 2) == 0);
         a   = {tags[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 12'($urandom)};
         b   = {$urandom, $urandom};
         p   = 12'($urandom_range(0, 2));
         drive(rn, ins, a, b, p);
         total++; if (hit !== m_hit(a, p)) begin bad++; $display("FAIL rnd_hit c=%0d got=%b want=%b", c, hit, m_hit(a, p)); end
         total++; if (miss !== !m_hit(a, p)) begin bad++; $display("FAIL rnd_miss c=%0d got=%b want=%b", c, miss, !m_hit(a, p)); end
         total++; if (o_addr !== m_addr(a, p)) begin bad++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, o_addr, m_addr(a, p)); end
      end
      drive(1'b1, 1'b0, 64'h0, 64'h0, 12'hFFF);
      for (int s = 0; s < 8; s++) begin
         total++; if (dut.plru_q[s] !== m_plru_vec(s)) begin bad++; $display("FAIL rnd_plru set=%0d got=%b want=%b", s, dut.plru_q[s], m_plru_vec(s)); end
      end
   endtask

   initial begin
      shutdown_n = 1'b0;
      insert     = 1'b0;
      va         = '0;
      pa         = '0;
      pcid       = '0;
      test_reset();
      test_insert();
      test_pcid_toggle();
      test_fill_replace();
      test_reinsert();
      test_shutdown_pulse();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
